// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        MADD  = 3'd2,
        MADDU = 3'd3,
        MSUB  = 3'd4,
        MSUBU = 3'd5,
        DIV   = 3'd6,
        DIVU  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed(input muldiv_op_t op);
        return (op == MULT) || (op == MADD) || (op == MSUB) || (op == DIV);
    endfunction

    function automatic logic is_acc(input muldiv_op_t op);
        return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
    endfunction

    function automatic logic is_sub(input muldiv_op_t op);
        return (op == MSUB) || (op == MSUBU);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Operand magnitude extraction and result sign restoration for signed ops.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic [WIDTH-1:0] abs_a,
    output logic [WIDTH-1:0] abs_b,
    output logic             neg_a,
    output logic             neg_b,
    input  logic [WIDTH-1:0] res_hi,
    input  logic [WIDTH-1:0] res_lo,
    input  logic             div,
    input  logic             neg_lo,
    input  logic             neg_hi,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    logic [2*WIDTH-1:0] prod_neg;

    assign neg_a = sgn & a[WIDTH-1];
    assign neg_b = sgn & b[WIDTH-1];
    assign abs_a = neg_a ? -a : a;
    assign abs_b = neg_b ? -b : b;

    assign prod_neg = -{res_hi, res_lo};

    // Divide fixes quotient and remainder independently; multiply negates the full product.
    always_comb begin
        fix_hi = res_hi;
        fix_lo = res_lo;
        if (div) begin
            if (neg_lo) fix_lo = -res_lo;
            if (neg_hi) fix_hi = -res_hi;
        end else if (neg_lo) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO accumulate support.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    muldiv_state_t      state;
    muldiv_op_t         op_in;
    muldiv_op_t         op;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   dividend;
    logic [2*WIDTH-1:0] acc;
    logic               b_zero;
    logic               neg_lo;
    logic               neg_hi;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shl;
    logic [WIDTH-1:0]   sub_d;
    logic               fits;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] acc_res;

    assign op_in = muldiv_op_t'(op_i);

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .a      (a_i),
        .b      (b_i),
        .sgn    (is_signed(op_in)),
        .abs_a  (abs_a),
        .abs_b  (abs_b),
        .neg_a  (neg_a),
        .neg_b  (neg_b),
        .res_hi (hi_r),
        .res_lo (lo_r),
        .div    (is_div(op)),
        .neg_lo (neg_lo),
        .neg_hi (neg_hi),
        .fix_hi (fix_hi),
        .fix_lo (fix_lo)
    );

    // Shift-add multiply step: hi accumulates, lo shifts out multiplier bits.
    assign add_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd} : '0);

    // Restoring divide step: remainder in hi, quotient shifts into lo.
    assign shl   = {hi_r, lo_r[WIDTH-1]};
    assign fits  = shl >= {1'b0, opnd};
    assign sub_d = shl[WIDTH-1:0] - opnd;

    assign prod    = {fix_hi, fix_lo};
    assign acc_res = is_sub(op) ? acc - prod : acc + prod;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            op            <= MULTU;
            cnt           <= '0;
            opnd          <= '0;
            hi_r          <= '0;
            lo_r          <= '0;
            dividend      <= '0;
            acc           <= '0;
            b_zero        <= 1'b0;
            neg_lo        <= 1'b0;
            neg_hi        <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
        end else begin
            done_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
            if (flush_i) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            state    <= ST_CALC;
                            busy_o   <= 1'b1;
                            op       <= op_in;
                            cnt      <= '0;
                            dividend <= a_i;
                            b_zero   <= (b_i == '0);
                            acc      <= {hi_i, lo_i};
                            neg_lo   <= neg_a ^ neg_b;
                            neg_hi   <= neg_a;
                            hi_r     <= '0;
                            opnd     <= is_div(op_in) ? abs_b : abs_a;
                            lo_r     <= is_div(op_in) ? abs_a : abs_b;
                        end
                    end
                    ST_CALC: begin
                        if (is_div(op)) begin
                            hi_r <= fits ? sub_d : shl[WIDTH-1:0];
                            lo_r <= {lo_r[WIDTH-2:0], fits};
                        end else begin
                            hi_r <= add_sum[WIDTH:1];
                            lo_r <= {add_sum[0], lo_r[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIXUP;
                    end
                    ST_FIXUP: begin
                        if (is_div(op) && b_zero) begin
                            hi_r <= dividend;
                            lo_r <= '1;
                        end else if (is_acc(op)) begin
                            {hi_r, lo_r} <= acc_res;
                        end else begin
                            {hi_r, lo_r} <= prod;
                        end
                        state <= ST_DONE;
                    end
                    ST_DONE: begin
                        hi_o          <= hi_r;
                        lo_o          <= lo_r;
                        done_o        <= 1'b1;
                        div_by_zero_o <= is_div(op) && b_zero;
                        busy_o        <= 1'b0;
                        state         <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
